// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle datapath controller: state codes,
// instruction opcode/op fields and one-hot select bit positions.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_GET_A     = 4'd2,
    S_GET_B     = 4'd3,
    S_ALU       = 4'd4,
    S_ALU_B     = 4'd5,
    S_CMP       = 4'd6,
    S_WRITE_C   = 4'd7,
    S_WRITE_IMM = 4'd8,
    S_ILLEGAL   = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  // opcode field
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field for OPC_ALU
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // op field for OPC_MOV
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // one-hot bit positions of nsel
  localparam int unsigned NSEL_RM = 0;
  localparam int unsigned NSEL_RD = 1;
  localparam int unsigned NSEL_RN = 2;

  // one-hot bit positions of vsel
  localparam int unsigned VSEL_C     = 0;
  localparam int unsigned VSEL_PC    = 1;
  localparam int unsigned VSEL_IMM   = 2;
  localparam int unsigned VSEL_MDATA = 3;

endpackage

// File: rtl/cpu_ctrl_state_reg.sv
// State register for cpu_ctrl_fsm; asynchronous active-high reset to WAIT.
module cpu_ctrl_state_reg
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] d,
  output logic [STATE_W-1:0] q
);

  // Hold the current state; reset drops straight back to WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= STATE_W'(S_WAIT);
    else       q <= d;
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Moore controller for the multi-cycle datapath (MOV imm/reg, ADD, CMP,
// AND, MVN). Optional macro CPU_CTRL_HALT_EN: opcode 111 enters a HALT
// state that holds until reset; otherwise opcode 111 is reported illegal.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned VSEL_W     = 4,
  parameter int unsigned NSEL_W     = 3,
  parameter bit          START_EDGE = 1'b0,
  parameter int unsigned STATE_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic [2:0]         opcode,
  input  logic [1:0]         op,
  output logic               w,
  output logic [NSEL_W-1:0]  nsel,
  output logic [VSEL_W-1:0]  vsel,
  output logic               write,
  output logic               loada,
  output logic               loadb,
  output logic               asel,
  output logic               bsel,
  output logic               loadc,
  output logic               loads,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [STATE_W-1:0] ST_WAIT      = STATE_W'(S_WAIT);
  localparam logic [STATE_W-1:0] ST_DECODE    = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_GET_A     = STATE_W'(S_GET_A);
  localparam logic [STATE_W-1:0] ST_GET_B     = STATE_W'(S_GET_B);
  localparam logic [STATE_W-1:0] ST_ALU       = STATE_W'(S_ALU);
  localparam logic [STATE_W-1:0] ST_ALU_B     = STATE_W'(S_ALU_B);
  localparam logic [STATE_W-1:0] ST_CMP       = STATE_W'(S_CMP);
  localparam logic [STATE_W-1:0] ST_WRITE_C   = STATE_W'(S_WRITE_C);
  localparam logic [STATE_W-1:0] ST_WRITE_IMM = STATE_W'(S_WRITE_IMM);
  localparam logic [STATE_W-1:0] ST_ILLEGAL   = STATE_W'(S_ILLEGAL);
  localparam logic [STATE_W-1:0] ST_HALT      = STATE_W'(S_HALT);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic               s_prev;
  logic               start;

  cpu_ctrl_state_reg #(
    .STATE_W(STATE_W)
  ) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (state_next),
    .q     (state)
  );

  // Start-request history; reset counts as "s seen high" so edge mode
  // needs s to drop before the first start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_prev <= 1'b1;
    else       s_prev <= s;
  end

  assign start     = START_EDGE ? (s & ~s_prev) : s;
  assign state_dbg = state;

  // Next-state sequencing; opcode/op are held stable by the decoder for
  // the whole instruction, so later states re-read them instead of latching.
  always_comb begin
    state_next = ST_WAIT;
    case (state)
      ST_WAIT:   state_next = start ? ST_DECODE : ST_WAIT;
      ST_DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM)      state_next = ST_WRITE_IMM;
        else if (opcode == OPC_MOV && op == OP_MOV_REG) state_next = ST_GET_B;
        else if (opcode == OPC_ALU)                     state_next = (op == OP_MVN) ? ST_GET_B : ST_GET_A;
`ifdef CPU_CTRL_HALT_EN
        else if (opcode == OPC_HALT)                    state_next = ST_HALT;
`else
        else if (opcode == OPC_HALT)                    state_next = ST_ILLEGAL;
`endif
        else                                            state_next = ST_ILLEGAL;
      end
      ST_GET_A:  state_next = ST_GET_B;
      ST_GET_B: begin
        if (opcode == OPC_ALU && (op == OP_ADD || op == OP_AND)) state_next = ST_ALU;
        else if (opcode == OPC_ALU && op == OP_CMP)              state_next = ST_CMP;
        else                                                     state_next = ST_ALU_B;
      end
      ST_ALU:       state_next = ST_WRITE_C;
      ST_ALU_B:     state_next = ST_WRITE_C;
      ST_CMP:       state_next = ST_WAIT;
      ST_WRITE_C:   state_next = ST_WAIT;
      ST_WRITE_IMM: state_next = ST_WAIT;
      ST_ILLEGAL:   state_next = ST_WAIT;
`ifdef CPU_CTRL_HALT_EN
      ST_HALT:      state_next = ST_HALT;
`else
      ST_HALT:      state_next = ST_WAIT;
`endif
      default:      state_next = ST_WAIT;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    w       = 1'b0;
    nsel    = '0;
    vsel    = '0;
    write   = 1'b0;
    loada   = 1'b0;
    loadb   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    illegal = 1'b0;
    case (state)
      ST_WAIT:  w = 1'b1;
      ST_GET_A: begin
        nsel[NSEL_RN] = 1'b1;
        loada         = 1'b1;
      end
      ST_GET_B: begin
        nsel[NSEL_RM] = 1'b1;
        loadb         = 1'b1;
      end
      ST_ALU:   loadc = 1'b1;
      ST_ALU_B: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      ST_CMP:   loads = 1'b1;
      ST_WRITE_C: begin
        vsel[VSEL_C]  = 1'b1;
        nsel[NSEL_RD] = 1'b1;
        write         = 1'b1;
      end
      ST_WRITE_IMM: begin
        vsel[VSEL_IMM] = 1'b1;
        nsel[NSEL_RN]  = 1'b1;
        write          = 1'b1;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm (level-start and
// edge-start instances). Honours CPU_CTRL_HALT_EN when defined.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  // Output bundle: {w, nsel[2:0], vsel[3:0], write, loada, loadb, asel,
  // bsel, loadc, loads, illegal}
  localparam logic [15:0] O_WAIT  = 16'h8000;
  localparam logic [15:0] O_ZERO  = 16'h0000;
  localparam logic [15:0] O_GETA  = 16'h4040;
  localparam logic [15:0] O_GETB  = 16'h1020;
  localparam logic [15:0] O_ALU   = 16'h0004;
  localparam logic [15:0] O_ALUB  = 16'h0014;
  localparam logic [15:0] O_CMP   = 16'h0002;
  localparam logic [15:0] O_WRC   = 16'h2180;
  localparam logic [15:0] O_WRI   = 16'h4480;
  localparam logic [15:0] O_ILL   = 16'h0001;

  logic       clk;
  logic       reset;
  logic       s;
  logic       s_e;
  logic [2:0] opcode;
  logic [1:0] op;

  logic       w, write, loada, loadb, asel, bsel, loadc, loads, illegal;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic [3:0] state_dbg;
  logic       w_e, write_e, loada_e, loadb_e, asel_e, bsel_e, loadc_e, loads_e, illegal_e;
  logic [2:0] nsel_e;
  logic [3:0] vsel_e;
  logic [3:0] state_e;
  logic [15:0] obs, obs_e;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_ctrl_fsm #(
    .VSEL_W(4), .NSEL_W(3), .START_EDGE(1'b0), .STATE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .write(write), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  cpu_ctrl_fsm #(
    .VSEL_W(4), .NSEL_W(3), .START_EDGE(1'b1), .STATE_W(4)
  ) dut_e (
    .clk(clk), .reset(reset), .s(s_e), .opcode(opcode), .op(op),
    .w(w_e), .nsel(nsel_e), .vsel(vsel_e), .write(write_e), .loada(loada_e),
    .loadb(loadb_e), .asel(asel_e), .bsel(bsel_e), .loadc(loadc_e), .loads(loads_e),
    .illegal(illegal_e), .state_dbg(state_e)
  );

  assign obs   = {w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, illegal};
  assign obs_e = {w_e, nsel_e, vsel_e, write_e, loada_e, loadb_e, asel_e, bsel_e,
                  loadc_e, loads_e, illegal_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s     = 1'b0;
    s_e   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (state_dbg !== 4'(S_WAIT) || obs !== O_WAIT) begin
      n_fail++;
      $display("FAIL reset_init: state=%0d out=%h expected state=%0d out=%h",
               state_dbg, obs, S_WAIT, O_WAIT);
    end
    @(negedge clk);
    reset  = 1'b0;
    opcode = 3'b101;
    op     = 2'b00;
    s      = 1'b1;
    tick();
    s = 1'b0;
    tick();
    tick();
    n_checks++;
    if (state_dbg !== 4'(S_GET_B) || obs !== O_GETB) begin
      n_fail++;
      $display("FAIL reset_pre_getb: state=%0d out=%h expected state=%0d out=%h",
               state_dbg, obs, S_GET_B, O_GETB);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state_dbg !== 4'(S_WAIT) || obs !== O_WAIT) begin
      n_fail++;
      $display("FAIL reset_mid_getb: state=%0d out=%h expected state=%0d out=%h",
               state_dbg, obs, S_WAIT, O_WAIT);
    end
    #1;
    reset = 1'b0;
    s     = 1'b1;
    tick();
    n_checks++;
    if (state_dbg !== 4'(S_DECODE) || obs !== O_ZERO) begin
      n_fail++;
      $display("FAIL reset_restart: state=%0d out=%h expected state=%0d out=%h",
               state_dbg, obs, S_DECODE, O_ZERO);
    end
  endtask

  task automatic test_mov_imm();
    logic [3:0]  es [4];
    logic [15:0] eo [4];
    es = '{S_DECODE, S_WRITE_IMM, S_WAIT, S_WAIT};
    eo = '{O_ZERO, O_WRI, O_WAIT, O_WAIT};
    do_reset();
    opcode = 3'b110;
    op     = 2'b10;
    s      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      s = 1'b0;
      n_checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        n_fail++;
        $display("FAIL mov_imm cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_mov_reg_mvn();
    logic [3:0]  es [6];
    logic [15:0] eo [6];
    logic [2:0]  vop [2];
    logic [1:0]  vo  [2];
    es  = '{S_DECODE, S_GET_B, S_ALU_B, S_WRITE_C, S_WAIT, S_WAIT};
    eo  = '{O_ZERO, O_GETB, O_ALUB, O_WRC, O_WAIT, O_WAIT};
    vop = '{3'b110, 3'b101};
    vo  = '{2'b00, 2'b11};
    for (int v = 0; v < 2; v++) begin
      do_reset();
      opcode = vop[v];
      op     = vo[v];
      s      = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        s = 1'b0;
        n_checks++;
        if (state_dbg !== es[i] || obs !== eo[i]) begin
          n_fail++;
          $display("FAIL movreg_mvn v%0d cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                   v, i, state_dbg, obs, es[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_alu();
    logic [3:0]  es [7];
    logic [15:0] eo [7];
    logic [1:0]  vo [2];
    es = '{S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WRITE_C, S_WAIT, S_WAIT};
    eo = '{O_ZERO, O_GETA, O_GETB, O_ALU, O_WRC, O_WAIT, O_WAIT};
    vo = '{2'b00, 2'b10};
    for (int v = 0; v < 2; v++) begin
      do_reset();
      opcode = 3'b101;
      op     = vo[v];
      s      = 1'b1;
      for (int i = 0; i < 7; i++) begin
        tick();
        s = 1'b0;
        n_checks++;
        if (state_dbg !== es[i] || obs !== eo[i]) begin
          n_fail++;
          $display("FAIL add_and v%0d cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                   v, i, state_dbg, obs, es[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_cmp();
    logic [3:0]  es [6];
    logic [15:0] eo [6];
    es = '{S_DECODE, S_GET_A, S_GET_B, S_CMP, S_WAIT, S_WAIT};
    eo = '{O_ZERO, O_GETA, O_GETB, O_CMP, O_WAIT, O_WAIT};
    do_reset();
    opcode = 3'b101;
    op     = 2'b01;
    s      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      s = 1'b0;
      n_checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        n_fail++;
        $display("FAIL cmp cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es [4];
    logic [15:0] eo [4];
    logic [2:0]  vop [5];
    logic [1:0]  vo  [5];
    es  = '{S_DECODE, S_ILLEGAL, S_WAIT, S_WAIT};
    eo  = '{O_ZERO, O_ILL, O_WAIT, O_WAIT};
    vop = '{3'b011, 3'b000, 3'b110, 3'b110, 3'b100};
    vo  = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      opcode = vop[v];
      op     = vo[v];
      s      = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        s = 1'b0;
        n_checks++;
        if (state_dbg !== es[i] || obs !== eo[i]) begin
          n_fail++;
          $display("FAIL illegal v%0d cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                   v, i, state_dbg, obs, es[i], eo[i]);
        end
      end
    end
  endtask

`ifdef CPU_CTRL_HALT_EN
  task automatic test_halt_opcode();
    do_reset();
    opcode = 3'b111;
    op     = 2'b01;
    s      = 1'b1;
    tick();
    s = 1'b0;
    n_checks++;
    if (state_dbg !== 4'(S_DECODE) || obs !== O_ZERO) begin
      n_fail++;
      $display("FAIL halt_decode: state=%0d out=%h expected state=%0d out=%h",
               state_dbg, obs, S_DECODE, O_ZERO);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) s = 1'b1;
      n_checks++;
      if (state_dbg !== 4'(S_HALT) || obs !== O_ZERO) begin
        n_fail++;
        $display("FAIL halt_hold cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                 i, state_dbg, obs, S_HALT, O_ZERO);
      end
    end
    s     = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state_dbg !== 4'(S_WAIT) || obs !== O_WAIT) begin
      n_fail++;
      $display("FAIL halt_reset: state=%0d out=%h expected state=%0d out=%h",
               state_dbg, obs, S_WAIT, O_WAIT);
    end
    reset = 1'b0;
  endtask
`else
  task automatic test_halt_opcode();
    logic [3:0]  es [3];
    logic [15:0] eo [3];
    es = '{S_DECODE, S_ILLEGAL, S_WAIT};
    eo = '{O_ZERO, O_ILL, O_WAIT};
    do_reset();
    opcode = 3'b111;
    op     = 2'b01;
    s      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      s = 1'b0;
      n_checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        n_fail++;
        $display("FAIL op111_illegal cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [3:0]  es [7];
    logic [15:0] eo [7];
    es = '{S_DECODE, S_WRITE_IMM, S_WAIT, S_DECODE, S_WRITE_IMM, S_WAIT, S_DECODE};
    eo = '{O_ZERO, O_WRI, O_WAIT, O_ZERO, O_WRI, O_WAIT, O_ZERO};
    do_reset();
    opcode = 3'b110;
    op     = 2'b10;
    s      = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
    end
    s = 1'b0;
  endtask

  task automatic test_start_edge();
    logic        sv [12];
    logic [3:0]  es [12];
    logic [15:0] eo [12];
    sv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    es = '{S_WAIT, S_WAIT, S_WAIT, S_DECODE, S_WRITE_IMM, S_WAIT,
           S_WAIT, S_WAIT, S_WAIT, S_DECODE, S_WRITE_IMM, S_WAIT};
    eo = '{O_WAIT, O_WAIT, O_WAIT, O_ZERO, O_WRI, O_WAIT,
           O_WAIT, O_WAIT, O_WAIT, O_ZERO, O_WRI, O_WAIT};
    @(negedge clk);
    reset  = 1'b1;
    s      = 1'b0;
    s_e    = 1'b1;
    opcode = 3'b110;
    op     = 2'b10;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_e = sv[i];
      tick();
      n_checks++;
      if (state_e !== es[i] || obs_e !== eo[i]) begin
        n_fail++;
        $display("FAIL start_edge cyc%0d: state=%0d out=%h expected state=%0d out=%h",
                 i, state_e, obs_e, es[i], eo[i]);
      end
    end
    s_e = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    s      = 1'b0;
    s_e    = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    test_reset();
    test_mov_imm();
    test_mov_reg_mvn();
    test_alu();
    test_cmp();
    test_illegal();
    test_halt_opcode();
    test_back_to_back();
    test_start_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
